vga_bus_arbiter: RTL and testbench

Two-port Wishbone arbiter that shares the single video-memory master bus between the active display-refresh engine and a CPU/blitter access path. It sits between the mode-selected graphics/text driver bus and the memory `outbus` inside the VGA subsystem. Display refresh has priority. A starvation counter guarantees the CPU port forward progress. An optional watchdog recovers from a hung slave.

---
 rtl/vga_bus_arbiter_if.sv | 26 ++
 rtl/vga_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vga_bus_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_bus_arbiter_if.sv
// Wishbone bus bundle shared by the VGA arbiter ports (adr 32 / dat 32 / sel 4).
// Latency: none, signal bundle only.
// Backpressure: stall from slave to master, ack completes a beat.
// Modports: master drives cyc/stb/we/adr/sel/dat_m and samples ack/stall/dat_s;
//           slave is the mirror image.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  ack, stall, dat_s
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output ack, stall, dat_s
  );
endinterface

// File: rtl/vga_bus_arbiter.sv
// Two-port Wishbone arbiter: display refresh (vid, priority) and CPU/blitter (cpu) share outbus.
// Latency: one cycle to grant from idle; data/control paths combinational once granted.
// Backpressure: non-owner sees stall=1; owner sees outbus stall/ack directly.
// Ports: clk_i, rst_i (sync, active-high); vid/cpu slave ports; outbus master port;
//        grant (00 idle, 01 vid, 10 cpu); timeout (one-cycle watchdog pulse).
// Optional hung-slave watchdog compiled in with VGA_ARB_WATCHDOG_EN.
module vga_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        vid,
  if_wb.slave        cpu,
  if_wb.master       outbus,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_VID  = 2'b01,
    ARB_CPU  = 2'b10
  } arb_state_t;

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [31:0] WD_DATA = 32'hdeadbeef;

  // Elaboration-time sanity check of the configuration.
  if (STARVE_LIMIT < 1 || TIMEOUT < 2) begin : g_param_chk
    $error("vga_bus_arbiter: STARVE_LIMIT must be >= 1 and TIMEOUT >= 2");
  end

  arb_state_t      state, state_nxt;
  logic [SC_W-1:0] starve_cnt;

  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic        own_ack;
  logic [31:0] own_dat_s;
  logic        wd_fire;

  // Owner request mux; everything is zero while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_sel = '0;
    own_dat = '0;
    case (state)
      ARB_VID: begin
        own_cyc = vid.cyc;
        own_stb = vid.stb;
        own_we  = vid.we;
        own_adr = vid.adr;
        own_sel = vid.sel;
        own_dat = vid.dat_m;
      end
      ARB_CPU: begin
        own_cyc = cpu.cyc;
        own_stb = cpu.stb;
        own_we  = cpu.we;
        own_adr = cpu.adr;
        own_sel = cpu.sel;
        own_dat = cpu.dat_m;
      end
      default: ;
    endcase
  end

`ifdef VGA_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts strobed cycles without ack; fires on the TIMEOUT-th such cycle.
  // Uses the owner's raw stb so the forced-off outbus strobe cannot feed back.
  assign wd_fire = (state != ARB_IDLE) && own_stb && (wd_cnt == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || state == ARB_IDLE || wd_fire || outbus.ack) begin
      wd_cnt <= '0;
    end else if (own_stb) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign timeout = wd_fire;
  assign grant   = state;

  // A watchdog abort completes the owner's beat with a poison word while
  // the shared bus cycle is dropped.
  assign own_ack   = outbus.ack | wd_fire;
  assign own_dat_s = wd_fire ? WD_DATA : outbus.dat_s;

  always_comb begin
    outbus.cyc   = own_cyc & ~wd_fire;
    outbus.stb   = own_stb & ~wd_fire;
    outbus.we    = own_we;
    outbus.adr   = own_adr;
    outbus.sel   = own_sel;
    outbus.dat_m = own_dat;
  end

  always_comb begin
    vid.stall = 1'b1;
    vid.ack   = 1'b0;
    vid.dat_s = '0;
    if (state == ARB_VID) begin
      vid.stall = outbus.stall;
      vid.ack   = own_ack;
      vid.dat_s = own_dat_s;
    end
  end

  always_comb begin
    cpu.stall = 1'b1;
    cpu.ack   = 1'b0;
    cpu.dat_s = '0;
    if (state == ARB_CPU) begin
      cpu.stall = outbus.stall;
      cpu.ack   = own_ack;
      cpu.dat_s = own_dat_s;
    end
  end

  // Next state: a starved cpu beats vid; otherwise vid has priority.
  // Every tenure returns through ARB_IDLE, giving the one-cycle bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (starve_cnt >= STARVE_MAX && cpu.cyc) state_nxt = ARB_CPU;
        else if (vid.cyc)                        state_nxt = ARB_VID;
        else if (cpu.cyc)                        state_nxt = ARB_CPU;
      end
      ARB_VID: if (!vid.cyc || wd_fire) state_nxt = ARB_IDLE;
      ARB_CPU: if (!cpu.cyc || wd_fire) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Waiting-cpu counter: cleared on entry to ARB_CPU, held (not cleared)
  // if the cpu withdraws its request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE && state_nxt == ARB_CPU) begin
      starve_cnt <= '0;
    end else if (cpu.cyc && state != ARB_CPU && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Directed bench for vga_bus_arbiter with STARVE_LIMIT=4, TIMEOUT=16.
// Outbus slave: zero-wait ack while ack_en is set, constant read data.
module tb_vga_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant;
  logic        timeout;
  logic        ack_en;
  logic [31:0] rd_data;
  int          total = 0;
  int          bad   = 0;

  if_wb vid ();
  if_wb cpu ();
  if_wb outbus ();

  always #5 clk = ~clk;

  assign outbus.ack   = ack_en & outbus.cyc & outbus.stb;
  assign outbus.stall = 1'b0;
  assign outbus.dat_s = rd_data;

  vga_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .vid     (vid),
    .cpu     (cpu),
    .outbus  (outbus),
    .grant   (grant),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    vid.cyc = 0; vid.stb = 0; vid.we = 0; vid.adr = '0; vid.sel = '0; vid.dat_m = '0;
    cpu.cyc = 0; cpu.stb = 0; cpu.we = 0; cpu.adr = '0; cpu.sel = '0; cpu.dat_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    ack_en = 1'b1;
    rd_data = 32'hcafef00d;
    clear_masters();
    vid.cyc = 1; vid.stb = 1;
    cpu.cyc = 1; cpu.stb = 1;

    // Reset held 3 cycles with both requesting.
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_out_cyc", 32'(outbus.cyc), 32'd0);
      chk("rst_vid_stall", 32'(vid.stall), 32'd1);
      chk("rst_cpu_stall", 32'(cpu.stall), 32'd1);
      chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    end
    rst = 1'b0;

    // Simultaneous requests: vid wins, 8 zero-wait beats.
    tick(); #1;
    chk("sim_starve", 32'(dut.starve_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick(); #1; end
      chk("vid_grant", 32'(grant), 32'd1);
      chk("vid_ack", 32'(vid.ack), 32'd1);
      chk("vid_stall", 32'(vid.stall), 32'd0);
      chk("cpu_wait_ack", 32'(cpu.ack), 32'd0);
      chk("cpu_wait_stall", 32'(cpu.stall), 32'd1);
    end
    tick();
    vid.cyc = 0; vid.stb = 0;
    #1;
    chk("vid_tail_grant", 32'(grant), 32'd1);
    chk("vid_tail_ack", 32'(vid.ack), 32'd0);
    tick(); #1;
    chk("bubble_grant", 32'(grant), 32'd0);
    chk("bubble_out_cyc", 32'(outbus.cyc), 32'd0);
    chk("bubble_cpu_ack", 32'(cpu.ack), 32'd0);
    tick(); #1;
    chk("cpu_grant", 32'(grant), 32'd2);
    chk("cpu_ack", 32'(cpu.ack), 32'd1);
    chk("cpu_starve_clr", 32'(dut.starve_cnt), 32'd0);
    chk("vid_nonowner_stall", 32'(vid.stall), 32'd1);
    tick();
    cpu.cyc = 0; cpu.stb = 0;
    #1;
    tick(); #1;
    chk("idle_after_cpu", 32'(grant), 32'd0);

    // Starvation: vid re-requests around every bubble while cpu waits.
    vid.cyc = 1; vid.stb = 1;
    cpu.cyc = 1; cpu.stb = 1;
    #1;
    tick(); #1;
    chk("stv_g1", 32'(grant), 32'd1);
    chk("stv_c1", 32'(dut.starve_cnt), 32'd1);
    tick();
    vid.cyc = 0; vid.stb = 0;
    #1;
    chk("stv_g2", 32'(grant), 32'd1);
    tick();
    vid.cyc = 1; vid.stb = 1;
    #1;
    chk("stv_g3", 32'(grant), 32'd0);
    chk("stv_c3", 32'(dut.starve_cnt), 32'd3);
    tick();
    vid.cyc = 0; vid.stb = 0;
    #1;
    chk("stv_g4", 32'(grant), 32'd1);
    chk("stv_c4", 32'(dut.starve_cnt), 32'd4);
    tick();
    vid.cyc = 1; vid.stb = 1;
    #1;
    chk("stv_g5", 32'(grant), 32'd0);
    chk("stv_sat", 32'(dut.starve_cnt), 32'd4);
    tick(); #1;
    chk("stv_cpu_grant", 32'(grant), 32'd2);
    chk("stv_clr", 32'(dut.starve_cnt), 32'd0);
    chk("stv_vid_ack", 32'(vid.ack), 32'd0);
    chk("stv_vid_stall", 32'(vid.stall), 32'd1);
    chk("stv_cpu_ack", 32'(cpu.ack), 32'd1);
    tick();
    clear_masters();
    #1;
    tick(); #1;
    chk("stv_idle", 32'(grant), 32'd0);

    // Data routing: cpu write then read.
    cpu.cyc = 1; cpu.stb = 1; cpu.we = 1;
    cpu.adr = 32'h00001000; cpu.dat_m = 32'h12345678; cpu.sel = 4'b0011;
    #1;
    chk("idle_out_adr", outbus.adr, 32'd0);
    chk("idle_out_sel", 32'(outbus.sel), 32'd0);
    chk("idle_out_we", 32'(outbus.we), 32'd0);
    chk("idle_out_dat", outbus.dat_m, 32'd0);
    tick(); #1;
    chk("wr_grant", 32'(grant), 32'd2);
    chk("wr_cyc", 32'(outbus.cyc), 32'd1);
    chk("wr_stb", 32'(outbus.stb), 32'd1);
    chk("wr_we", 32'(outbus.we), 32'd1);
    chk("wr_adr", outbus.adr, 32'h00001000);
    chk("wr_dat", outbus.dat_m, 32'h12345678);
    chk("wr_sel", 32'(outbus.sel), 32'h3);
    tick();
    cpu.we = 0;
    #1;
    chk("rd_we", 32'(outbus.we), 32'd0);
    chk("rd_cpu_dat", cpu.dat_s, 32'hcafef00d);
    chk("rd_vid_dat", vid.dat_s, 32'd0);
    tick();
    clear_masters();
    #1;
    tick(); #1;
    chk("rd_idle", 32'(grant), 32'd0);
    chk("rd_idle_dat", cpu.dat_s, 32'd0);

    // Reset in the middle of a vid beat.
    vid.cyc = 1; vid.stb = 1;
    #1;
    tick(); #1;
    chk("mid_vid_ack", 32'(vid.ack), 32'd1);
    rst = 1'b1;
    tick(); #1;
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_out_cyc", 32'(outbus.cyc), 32'd0);
    chk("mid_vid_ack_drop", 32'(vid.ack), 32'd0);
    chk("mid_vid_stall", 32'(vid.stall), 32'd1);
    rst = 1'b0;
    clear_masters();
    tick(); #1;
    chk("mid_idle", 32'(grant), 32'd0);

    // Hung slave on a cpu read.
    ack_en = 1'b0;
    cpu.cyc = 1; cpu.stb = 1; cpu.adr = 32'h00002000;
    #1;
    tick(); #1;
    for (int i = 0; i < 15; i++) begin
      chk("hung_grant", 32'(grant), 32'd2);
      chk("hung_ack", 32'(cpu.ack), 32'd0);
      chk("hung_timeout", 32'(timeout), 32'd0);
      tick(); #1;
    end
`ifdef VGA_ARB_WATCHDOG_EN
    chk("wd_ack", 32'(cpu.ack), 32'd1);
    chk("wd_dat", cpu.dat_s, 32'hdeadbeef);
    chk("wd_pulse", 32'(timeout), 32'd1);
    chk("wd_out_cyc", 32'(outbus.cyc), 32'd0);
    tick(); #1;
    chk("wd_after_grant", 32'(grant), 32'd0);
    chk("wd_after_pulse", 32'(timeout), 32'd0);
`else
    chk("nowd_ack", 32'(cpu.ack), 32'd0);
    chk("nowd_pulse", 32'(timeout), 32'd0);
    chk("nowd_out_cyc", 32'(outbus.cyc), 32'd1);
    tick(); #1;
    chk("nowd_grant_held", 32'(grant), 32'd2);
`endif
    clear_masters();
    ack_en = 1'b1;
    tick(); #1;
    tick(); #1;
    chk("end_idle", 32'(grant), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
